lsu_data_mem_ctrl: RTL and testbench

- Load/store controller directly upstream of data_mem.
- Accepts one byte/halfword/word load or store request from the execute stage and drives data_mem's wr_sel/addr/wr_data ports.
- Performs read-modify-write for sub-word stores, extracts and extends sub-word load data, and flags misaligned accesses.
- data_mem contract: combinational read of the word at addr; word write at posedge clk when wr_sel=1.

---
 rtl/lsu_data_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_lsu_data_mem_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_data_mem_ctrl.sv
// Load/store controller in front of data_mem: aligns accesses, does read-modify-write
// for sub-word stores and extends sub-word loads. Optional counters: LSU_PERF_CNT_EN.
module lsu_data_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [31:0]           resp_rdata,
    output logic                  mem_wr_sel,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wr_data,
    input  logic [31:0]           mem_rd_data
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]           perf_loads,
    output logic [31:0]           perf_stores,
    output logic [31:0]           perf_errs
`endif
);

    if (DATA_WIDTH != 32) begin : g_width_check
        $error("lsu_data_mem_ctrl: DATA_WIDTH must be 32");
    end

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t                state;
    state_t                state_next;
    logic                  is_store_q;
    logic [1:0]            size_q;
    logic                  unsigned_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           word_q;
    logic                  err_q;
    logic                  req_err_c;
    logic [BYTE_W-1:0]     byte_v;
    logic [HALF_W-1:0]     half_v;
    logic [31:0]           load_val;
    logic [31:0]           merged;

    assign req_err_c = (req_size == SZ_BAD)
                    || ((req_size == SZ_HALF) && req_addr[0])
                    || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err_c)                                 state_next = RESP;
                    else if (req_is_store && req_size == SZ_WORD)  state_next = WR;
                    else                                           state_next = RD;
                end
            end
            RD:      state_next = is_store_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture and read-phase word capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            word_q     <= 32'd0;
            err_q      <= 1'b0;
        end else if (state == IDLE && req_valid) begin
            is_store_q <= req_is_store;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            word_q     <= 32'd0;
            err_q      <= req_err_c;
        end else if (state == RD) begin
            word_q     <= mem_rd_data;
        end
    end

    // Outputs decoded from state and captured request fields
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        resp_rdata  = 32'd0;
        mem_wr_sel  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = 32'd0;
        byte_v      = word_q[{addr_q[1:0], 3'b000} +: BYTE_W];
        half_v      = word_q[{addr_q[1], 4'b0000} +: HALF_W];
        load_val    = word_q;
        merged      = wdata_q;

        case (size_q)
            SZ_BYTE: begin
                load_val = unsigned_q ? {24'd0, byte_v} : {{24{byte_v[BYTE_W-1]}}, byte_v};
                merged   = word_q;
                merged[{addr_q[1:0], 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
            end
            SZ_HALF: begin
                load_val = unsigned_q ? {16'd0, half_v} : {{16{half_v[HALF_W-1]}}, half_v};
                merged   = word_q;
                merged[{addr_q[1], 4'b0000} +: HALF_W] = wdata_q[HALF_W-1:0];
            end
            default: begin
                load_val = word_q;
                merged   = wdata_q;
            end
        endcase

        case (state)
            IDLE: req_ready = 1'b1;
            RD:   mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            WR: begin
                mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                mem_wr_sel  = 1'b1;
                mem_wr_data = merged;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!err_q && !is_store_q) resp_rdata = load_val;
            end
            default: req_ready = 1'b0;
        endcase
    end

`ifdef LSU_PERF_CNT_EN
    // Saturating completion counters, bumped on the response cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads  <= 32'd0;
            perf_stores <= 32'd0;
            perf_errs   <= 32'd0;
        end else if (state == RESP) begin
            if (err_q) begin
                if (perf_errs != 32'hFFFF_FFFF) perf_errs <= perf_errs + 32'd1;
            end else if (is_store_q) begin
                if (perf_stores != 32'hFFFF_FFFF) perf_stores <= perf_stores + 32'd1;
            end else begin
                if (perf_loads != 32'hFFFF_FFFF) perf_loads <= perf_loads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_data_mem_ctrl.sv
// Bench for lsu_data_mem_ctrl: directed scenarios plus randomized traffic against an
// arithmetic memory model. Counter checks are included when LSU_PERF_CNT_EN is defined.
module tb_lsu_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_wr_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads;
    logic [31:0] perf_stores;
    logic [31:0] perf_errs;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int bad_addr = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];

    always #5 clk = ~clk;

    lsu_data_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_wr_sel   (mem_wr_sel),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data)
`ifdef LSU_PERF_CNT_EN
        ,
        .perf_loads   (perf_loads),
        .perf_stores  (perf_stores),
        .perf_errs    (perf_errs)
`endif
    );

    // data_mem stand-in: combinational read, word write on rising edge
    assign mem_rd_data = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_wr_sel) mem[mem_addr[7:2]] <= mem_wr_data;

    // Present one request, wait for its response (bounded), report what was seen
    task automatic do_req(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [7:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int wrs, output logic rdy);
        @(negedge clk);
        rdy          = req_ready;
        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = {24'd0, a};
        req_wdata    = wd;
        @(posedge clk);
        lat = 0; wrs = 0; rd = 32'd0; er = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) req_valid = 1'b0;
            if (mem_wr_sel) wrs++;
            if (mem_addr[31:8] != 24'd0 || mem_addr[1:0] != 2'b00) bad_addr++;
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    // Reference behaviour from the access rules, updating ref_mem for stores
    function automatic void model(input logic st, input logic [1:0] sz, input logic uns,
                                  input logic [7:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic er,
                                  output int lat, output int wrs);
        logic [31:0] w;
        int unsigned sh;
        w  = ref_mem[a / 4];
        sh = 8 * (a % 4);
        rd = 32'd0; wrs = 0;
        er = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
        if (er) begin
            lat = 1;
        end else if (!st) begin
            lat = 2;
            if (sz == 2'd0) begin
                rd = (w >> sh) & 32'hFF;
                if (!uns && rd >= 32'h80) rd = rd | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                rd = (w >> sh) & 32'hFFFF;
                if (!uns && rd >= 32'h8000) rd = rd | 32'hFFFF_0000;
            end else begin
                rd = w;
            end
        end else begin
            wrs = 1;
            if (sz == 2'd2) begin
                lat = 2;
                ref_mem[a / 4] = wd;
            end else if (sz == 2'd0) begin
                lat = 3;
                ref_mem[a / 4] = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            end else begin
                lat = 3;
                ref_mem[a / 4] = (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_checks += 7;
        if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else n_pass++;
        if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else n_pass++;
        if (resp_err !== 1'b0) $display("FAIL reset_resp_err got %b want 0", resp_err); else n_pass++;
        if (resp_rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", resp_rdata); else n_pass++;
        if (mem_wr_sel !== 1'b0) $display("FAIL reset_wr_sel got %b want 0", mem_wr_sel); else n_pass++;
        if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else n_pass++;
        if (mem_wr_data !== 32'd0) $display("FAIL reset_wr_data got %h want 0", mem_wr_data); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_store_load();
        logic [31:0] rd; logic er, rdy; int lat, wrs;
        do_req(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, rd, er, lat, wrs, rdy);
        n_checks += 5;
        if (rdy !== 1'b1) $display("FAIL wst_ready got %b want 1", rdy); else n_pass++;
        if (wrs != 1) $display("FAIL wst_wr_pulses got %0d want 1", wrs); else n_pass++;
        if (lat != 2) $display("FAIL wst_latency got %0d want 2", lat); else n_pass++;
        if (er !== 1'b0) $display("FAIL wst_err got %b want 0", er); else n_pass++;
        if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL wst_mem got %h want deadbeef", mem[4]); else n_pass++;
        do_req(1'b0, 2'd2, 1'b0, 8'h10, 32'd0, rd, er, lat, wrs, rdy);
        n_checks += 4;
        if (rd !== 32'hDEAD_BEEF) $display("FAIL wld_rdata got %h want deadbeef", rd); else n_pass++;
        if (er !== 1'b0) $display("FAIL wld_err got %b want 0", er); else n_pass++;
        if (lat != 2) $display("FAIL wld_latency got %0d want 2", lat); else n_pass++;
        if (wrs != 0) $display("FAIL wld_wr_pulses got %0d want 0", wrs); else n_pass++;
    endtask

    task automatic test_subword_store();
        logic [31:0] rd; logic er, rdy; int lat, wrs;
        do_req(1'b1, 2'd2, 1'b0, 8'h20, 32'h1122_3344, rd, er, lat, wrs, rdy);
        do_req(1'b1, 2'd0, 1'b0, 8'h22, 32'h1234_56AA, rd, er, lat, wrs, rdy);
        n_checks += 5;
        if (lat != 3) $display("FAIL sbst_latency got %0d want 3", lat); else n_pass++;
        if (wrs != 1) $display("FAIL sbst_wr_pulses got %0d want 1", wrs); else n_pass++;
        if (er !== 1'b0) $display("FAIL sbst_err got %b want 0", er); else n_pass++;
        if (rd !== 32'd0) $display("FAIL sbst_rdata got %h want 0", rd); else n_pass++;
        if (mem[8] !== 32'h11AA_3344) $display("FAIL sbst_mem got %h want 11aa3344", mem[8]); else n_pass++;
        do_req(1'b1, 2'd1, 1'b0, 8'h22, 32'hFFFF_BEEF, rd, er, lat, wrs, rdy);
        n_checks++;
        if (mem[8] !== 32'hBEEF_3344) $display("FAIL shst_mem got %h want beef3344", mem[8]); else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [31:0] rd; logic er, rdy; int lat, wrs;
        logic [7:0]  addrs [6] = '{8'h32, 8'h32, 8'h30, 8'h33, 8'h33, 8'h32};
        logic [1:0]  sizes [6] = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
        logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] exps  [6] = '{32'hFFFF_FFFF, 32'h0000_80FF, 32'h0000_7F01,
                                   32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_80FF};
        do_req(1'b1, 2'd2, 1'b0, 8'h30, 32'h80FF_7F01, rd, er, lat, wrs, rdy);
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, sizes[i], unss[i], addrs[i], 32'd0, rd, er, lat, wrs, rdy);
            n_checks += 2;
            if (rd !== exps[i]) $display("FAIL ext_rdata[%0d] got %h want %h", i, rd, exps[i]); else n_pass++;
            if (lat != 2) $display("FAIL ext_latency[%0d] got %0d want 2", i, lat); else n_pass++;
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, rdy; int lat, wrs;
        logic        sts   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [1:0]  sizes [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd1};
        logic [7:0]  addrs [5] = '{8'h41, 8'h43, 8'h40, 8'h42, 8'h41};
        do_req(1'b1, 2'd2, 1'b0, 8'h40, 32'h5566_7788, rd, er, lat, wrs, rdy);
        for (int i = 0; i < 5; i++) begin
            do_req(sts[i], sizes[i], 1'b0, addrs[i], 32'hA5A5_A5A5, rd, er, lat, wrs, rdy);
            n_checks += 4;
            if (er !== 1'b1) $display("FAIL err_flag[%0d] got %b want 1", i, er); else n_pass++;
            if (rd !== 32'd0) $display("FAIL err_rdata[%0d] got %h want 0", i, rd); else n_pass++;
            if (lat != 1) $display("FAIL err_latency[%0d] got %0d want 1", i, lat); else n_pass++;
            if (wrs != 0) $display("FAIL err_wr_pulses[%0d] got %0d want 0", i, wrs); else n_pass++;
        end
        n_checks++;
        if (mem[16] !== 32'h5566_7788) $display("FAIL err_mem got %h want 55667788", mem[16]); else n_pass++;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, rdy; int lat, wrs;
        int wr_seen = 0;
        do_req(1'b1, 2'd2, 1'b0, 8'h50, 32'hCAFE_F00D, rd, er, lat, wrs, rdy);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'd0;
        req_addr = 32'h51; req_wdata = 32'h0000_00EE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++;
        if (mem_addr !== 32'h50) $display("FAIL abort_rd_addr got %h want 50", mem_addr); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (mem_wr_sel !== 1'b0) $display("FAIL abort_wr_sel got %b want 0", mem_wr_sel); else n_pass++;
        if (mem_addr !== 32'd0) $display("FAIL abort_mem_addr got %h want 0", mem_addr); else n_pass++;
        if (resp_valid !== 1'b0) $display("FAIL abort_resp_valid got %b want 0", resp_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (mem_wr_sel) wr_seen++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (mem_wr_sel) wr_seen++;
        end
        n_checks += 3;
        if (wr_seen != 0) $display("FAIL abort_writes got %0d want 0", wr_seen); else n_pass++;
        if (req_ready !== 1'b1) $display("FAIL abort_ready got %b want 1", req_ready); else n_pass++;
        if (mem[20] !== 32'hCAFE_F00D) $display("FAIL abort_mem got %h want cafef00d", mem[20]); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, wd; logic er, eer, rdy, st, uns; int lat, elat, wrs, ewrs;
        logic [1:0] sz; logic [7:0] a;
        int diffs = 0;
        for (int i = 0; i < 64; i++) begin
            wd = $urandom;
            do_req(1'b1, 2'd2, 1'b0, 8'(i * 4), wd, rd, er, lat, wrs, rdy);
            ref_mem[i] = wd;
        end
        bad_addr = 0;
        for (int n = 0; n < 250; n++) begin
            st  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            wd = $urandom;
            model(st, sz, uns, a, wd, erd, eer, elat, ewrs);
            do_req(st, sz, uns, a, wd, rd, er, lat, wrs, rdy);
            n_checks += 5;
            if (rd !== erd) $display("FAIL rnd_rdata[%0d] got %h want %h", n, rd, erd); else n_pass++;
            if (er !== eer) $display("FAIL rnd_err[%0d] got %b want %b", n, er, eer); else n_pass++;
            if (lat != elat) $display("FAIL rnd_latency[%0d] got %0d want %0d", n, lat, elat); else n_pass++;
            if (wrs != ewrs) $display("FAIL rnd_wr_pulses[%0d] got %0d want %0d", n, wrs, ewrs); else n_pass++;
            if (rdy !== 1'b1) $display("FAIL rnd_ready[%0d] got %b want 1", n, rdy); else n_pass++;
        end
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
        n_checks += 2;
        if (diffs != 0) $display("FAIL rnd_mem_words got %0d differing want 0", diffs); else n_pass++;
        if (bad_addr != 0) $display("FAIL rnd_mem_addr got %0d unaligned want 0", bad_addr); else n_pass++;
    endtask

`ifdef LSU_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] rd; logic er, rdy; int lat, wrs;
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (perf_loads !== 32'd0) $display("FAIL perf_reset got %0d want 0", perf_loads); else n_pass++;
        do_req(1'b0, 2'd2, 1'b0, 8'h00, 32'd0, rd, er, lat, wrs, rdy);
        do_req(1'b1, 2'd0, 1'b0, 8'h05, 32'h11, rd, er, lat, wrs, rdy);
        do_req(1'b0, 2'd0, 1'b0, 8'h05, 32'd0, rd, er, lat, wrs, rdy);
        do_req(1'b0, 2'd2, 1'b0, 8'h01, 32'd0, rd, er, lat, wrs, rdy);
        do_req(1'b1, 2'd2, 1'b0, 8'h08, 32'h22, rd, er, lat, wrs, rdy);
        do_req(1'b0, 2'd1, 1'b1, 8'h0A, 32'd0, rd, er, lat, wrs, rdy);
        @(negedge clk);
        n_checks += 3;
        if (perf_loads !== 32'd3) $display("FAIL perf_loads got %0d want 3", perf_loads); else n_pass++;
        if (perf_stores !== 32'd2) $display("FAIL perf_stores got %0d want 2", perf_stores); else n_pass++;
        if (perf_errs !== 32'd1) $display("FAIL perf_errs got %0d want 1", perf_errs); else n_pass++;
    endtask
`endif

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        test_reset();
        test_word_store_load();
        test_subword_store();
        test_load_ext();
        test_errors();
        test_reset_abort();
        test_random();
`ifdef LSU_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
